oam_dma_ctrl: RTL and testbench

Sprite DMA engine that sits directly on the CPU core's external bus, between the core and the memory/PPU decode. It snoops CPU writes to the DMA trigger register. On a trigger it stalls the core through its clock-enable and copies one 256-byte page to the sprite data port as 256 read/write pairs. It muxes its own bus cycles onto the shared address/data/strobe lines while the core is held.

---
 rtl/oam_dma_ctrl.sv | 150 +++++++++++++++
 tb/tb_oam_dma_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA engine: snoops the CPU trigger write, stalls the core and copies a 256-byte page to the sprite port.
// Optional feature macro: OAM_DMA_DONE_PULSE_EN adds a one-ce-cycle dma_done pulse when the core resumes.
`timescale 1ns/1ps
module oam_dma_ctrl #(
    parameter logic [15:0] REG_ADDR   = 16'h4014,
    parameter logic [15:0] WRITE_ADDR = 16'h2004
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ce,
    input  logic [15:0] cpu_aout,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_mr,
    input  logic        cpu_mw,
    input  logic [7:0]  din,
    output logic        cpu_ce,
    output logic [15:0] bus_aout,
    output logic [7:0]  bus_dout,
    output logic        bus_mr,
    output logic        bus_mw,
`ifdef OAM_DMA_DONE_PULSE_EN
    output logic        dma_done,
`endif
    output logic        dma_active
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PEND  = 3'd1,
        ST_HALT  = 3'd2,
        ST_ALIGN = 3'd3,
        ST_RD    = 3'd4,
        ST_WR    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic        parity_q;
    logic        trig_s;
    logic        last_s;

    assign trig_s = cpu_mw && (cpu_aout == REG_ADDR);
    assign last_s = (state_q == ST_WR) && (idx_q == 8'hFF);

    // Next-state logic and bus mux; the PEND stall cycle behaves as HALT while the core is parked on a read.
    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        idx_d      = idx_q;
        data_d     = data_q;
        cpu_ce     = ce;
        bus_aout   = cpu_aout;
        bus_dout   = cpu_dout;
        bus_mr     = cpu_mr;
        bus_mw     = cpu_mw;
        dma_active = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trig_s) begin
                    page_d  = cpu_dout;
                    idx_d   = 8'd0;
                    state_d = ST_PEND;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (cpu_mw) begin
                    if (trig_s) begin
                        page_d = cpu_dout;
                    end else begin
                        page_d = page_q;
                    end
                end else begin
                    cpu_ce     = 1'b0;
                    dma_active = 1'b1;
                    bus_mr     = 1'b1;
                    bus_mw     = 1'b0;
                    // Reads must land on even parity, so an odd stall goes straight to RD.
                    state_d    = parity_q ? ST_RD : ST_ALIGN;
                end
            end
            ST_HALT, ST_ALIGN: begin
                cpu_ce     = 1'b0;
                dma_active = 1'b1;
                bus_mr     = 1'b1;
                bus_mw     = 1'b0;
                state_d    = ST_RD;
            end
            ST_RD: begin
                cpu_ce     = 1'b0;
                dma_active = 1'b1;
                bus_aout   = {page_q, idx_q};
                bus_dout   = data_q;
                bus_mr     = 1'b1;
                bus_mw     = 1'b0;
                data_d     = din;
                state_d    = ST_WR;
            end
            ST_WR: begin
                cpu_ce     = 1'b0;
                dma_active = 1'b1;
                bus_aout   = WRITE_ADDR;
                bus_dout   = data_q;
                bus_mr     = 1'b0;
                bus_mw     = 1'b1;
                idx_d      = idx_q + 8'd1;
                state_d    = last_s ? ST_IDLE : ST_RD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers advance only on enabled cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            page_q   <= 8'd0;
            idx_q    <= 8'd0;
            data_q   <= 8'd0;
            parity_q <= 1'b0;
        end else if (ce) begin
            state_q  <= state_d;
            page_q   <= page_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            parity_q <= ~parity_q;
        end
    end

`ifdef OAM_DMA_DONE_PULSE_EN
    logic done_q;

    // Done pulse set by the final write and cleared by the next enabled cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q <= 1'b0;
        end else if (ce) begin
            done_q <= last_s;
        end
    end

    assign dma_done = done_q;
`endif

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Randomized self-checking bench for oam_dma_ctrl against a transfer-level reference model.
// Define OAM_DMA_DONE_PULSE_EN on both files to also check the dma_done pulse.
`timescale 1ns/1ps
module tb_oam_dma_ctrl;

    localparam logic [15:0] REG_ADDR   = 16'h4014;
    localparam logic [15:0] WRITE_ADDR = 16'h2004;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ce = 1'b0;
    logic [15:0] cpu_aout = 16'h0000;
    logic [7:0]  cpu_dout = 8'h00;
    logic        cpu_mr = 1'b0;
    logic        cpu_mw = 1'b0;
    logic [7:0]  din;
    logic        cpu_ce;
    logic [15:0] bus_aout;
    logic [7:0]  bus_dout;
    logic        bus_mr;
    logic        bus_mw;
    logic        dma_active;
`ifdef OAM_DMA_DONE_PULSE_EN
    logic        dma_done;
`endif

    logic [7:0] mem [0:65535];

    typedef struct packed {
        logic [15:0] a;
        logic [7:0]  d;
        logic        mr;
        logic        mw;
        logic        par;
    } tr_t;

    tr_t trace[$];
    int  vectors = 0;
    int  miscompares = 0;
    int  ce_cnt = 0;
    int  stall_cnt = 0;
    int  done_cnt = 0;
    bit  done_at_resume = 1'b0;
    int  ce_mode = 0;
    bit  tog = 1'b0;
    bit  last_cpu_ce = 1'b0;

    oam_dma_ctrl #(.REG_ADDR(REG_ADDR), .WRITE_ADDR(WRITE_ADDR)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .cpu_aout(cpu_aout),
        .cpu_dout(cpu_dout),
        .cpu_mr(cpu_mr),
        .cpu_mw(cpu_mw),
        .din(din),
        .cpu_ce(cpu_ce),
        .bus_aout(bus_aout),
        .bus_dout(bus_dout),
        .bus_mr(bus_mr),
        .bus_mw(bus_mw),
`ifdef OAM_DMA_DONE_PULSE_EN
        .dma_done(dma_done),
`endif
        .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    assign din = mem[bus_aout];

    // One clock: drive at the falling edge, observe 1 ns later, log what the memory side saw.
    task automatic step(input logic [15:0] a, input logic [7:0] d, input logic mr, input logic mw);
        logic ce_v;
        @(negedge clk);
        case (ce_mode)
            0: ce_v = 1'b1;
            1: begin tog = ~tog; ce_v = tog; end
            default: ce_v = 1'($urandom_range(0, 1));
        endcase
        cpu_aout = a; cpu_dout = d; cpu_mr = mr; cpu_mw = mw; ce = ce_v;
        #1;
        last_cpu_ce = cpu_ce;
        if (!dma_active) begin
            vectors++;
            if (cpu_ce !== ce_v || bus_aout !== a || bus_dout !== d || bus_mr !== mr || bus_mw !== mw) begin
                miscompares++;
                $display("FAIL passthru: got ce=%b a=%h d=%h mr=%b mw=%b expected ce=%b a=%h d=%h mr=%b mw=%b",
                         cpu_ce, bus_aout, bus_dout, bus_mr, bus_mw, ce_v, a, d, mr, mw);
            end
        end else begin
            vectors++;
            if (cpu_ce !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_cpu_ce: got %b expected 0", cpu_ce);
            end
        end
        if (reset_n && ce_v) begin
            if (dma_active) trace.push_back('{bus_aout, bus_dout, bus_mr, bus_mw, ce_cnt[0]});
            if (!cpu_ce) stall_cnt++;
`ifdef OAM_DMA_DONE_PULSE_EN
            if (dma_done) done_cnt++;
            if (dma_done && cpu_ce) done_at_resume = 1'b1;
`endif
            ce_cnt++;
        end
    endtask

    // A core bus cycle: repeated while the core is held, bounded so a stuck stall cannot hang the run.
    task automatic bus_cycle(input logic [15:0] a, input logic [7:0] d, input logic mr, input logic mw,
                             output int tries);
        tries = 0;
        do begin
            step(a, d, mr, mw);
            tries++;
        end while (!last_cpu_ce && tries < 3000);
        if (!last_cpu_ce) begin
            miscompares++;
            $display("FAIL bus_cycle_timeout: addr=%h still stalled after %0d cycles", a, tries);
        end
    endtask

    // Reference: optional dummy reads, then 256 RD/WR pairs sourced from {page, i}.
    task automatic check_trace(input logic [7:0] page, input int want_par, input logic [15:0] rd_addr);
        int nd, exp_len, j;
        logic [15:0] ea;
        logic [7:0]  ed;
        logic        emr, emw, ok;
        vectors++;
        if (trace.size() == 0) begin
            miscompares++;
            $display("FAIL xfer_len: got 0 active cycles expected 513 or 514");
            return;
        end
        nd = trace[0].par ? 1 : 2;
        exp_len = 512 + nd;
        if (trace.size() != exp_len) begin
            miscompares++;
            $display("FAIL xfer_len: got %0d expected %0d", trace.size(), exp_len);
        end
        if (want_par >= 0) begin
            vectors++;
            if (trace[0].par !== want_par[0]) begin
                miscompares++;
                $display("FAIL stall_parity: got %b expected %0d", trace[0].par, want_par);
            end
        end
        vectors++;
        if (stall_cnt != exp_len) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d expected %0d", stall_cnt, exp_len);
        end
        for (int i = 0; i < trace.size() && i < exp_len; i++) begin
            vectors++;
            ed = 8'h00;
            if (i < nd) begin
                ea = rd_addr; emr = 1'b1; emw = 1'b0;
                ok = trace[i].a === ea && trace[i].mr === emr && trace[i].mw === emw;
            end else begin
                j = (i - nd) / 2;
                if (((i - nd) % 2) == 0) begin
                    ea = {page, j[7:0]}; emr = 1'b1; emw = 1'b0;
                    ok = trace[i].a === ea && trace[i].mr === emr && trace[i].mw === emw && trace[i].par === 1'b0;
                end else begin
                    ea = WRITE_ADDR; ed = mem[{page, j[7:0]}]; emr = 1'b0; emw = 1'b1;
                    ok = trace[i].a === ea && trace[i].d === ed && trace[i].mr === emr && trace[i].mw === emw;
                end
            end
            if (!ok) begin
                miscompares++;
                $display("FAIL xfer[%0d]: got a=%h d=%h mr=%b mw=%b par=%b expected a=%h d=%h mr=%b mw=%b",
                         i, trace[i].a, trace[i].d, trace[i].mr, trace[i].mw, trace[i].par, ea, ed, emr, emw);
            end
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++) begin
            ce_mode = 2;
            step(16'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            vectors++;
            if (dma_active !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_active: got %b expected 0", dma_active);
            end
        end
        @(negedge clk);
        ce = 1'b0;
        #1 reset_n = 1'b1;
        ce_cnt = 0;
    endtask

    task automatic test_dma(input logic [7:0] page, input logic [7:0] page2, input int want_par,
                            input int mode, input bit b2b);
        int tries;
        logic [7:0] exp_page;
        logic [15:0] rd_addr;
        trace.delete();
        stall_cnt = 0;
        done_cnt = 0;
        done_at_resume = 1'b0;
        ce_mode = 0;
        if (want_par >= 0 && ((ce_cnt + 1) % 2) != want_par) bus_cycle(16'h8000, 8'h00, 1'b1, 1'b0, tries);
        ce_mode = mode;
        bus_cycle(REG_ADDR, page, 1'b0, 1'b1, tries);
        exp_page = page;
        if (b2b) begin
            bus_cycle(REG_ADDR, page2, 1'b0, 1'b1, tries);
            vectors++;
            if (tries != 1) begin
                miscompares++;
                $display("FAIL b2b_write1: got %0d tries expected 1", tries);
            end
            bus_cycle(16'h0100, 8'($urandom), 1'b0, 1'b1, tries);
            vectors++;
            if (tries != 1) begin
                miscompares++;
                $display("FAIL b2b_write2: got %0d tries expected 1", tries);
            end
            exp_page = page2;
        end
        rd_addr = 16'h8000 | 16'($urandom_range(1, 16'h0FFF));
        bus_cycle(rd_addr, 8'h00, 1'b1, 1'b0, tries);
        check_trace(exp_page, want_par, rd_addr);
`ifdef OAM_DMA_DONE_PULSE_EN
        vectors++;
        if (done_cnt != 1 || !done_at_resume) begin
            miscompares++;
            $display("FAIL dma_done: got %0d pulses at_resume=%b expected 1 pulse at_resume=1", done_cnt, done_at_resume);
        end
`endif
        ce_mode = 0;
        bus_cycle(16'h8000, 8'h00, 1'b1, 1'b0, tries);
    endtask

    task automatic test_reset_mid();
        int tries, nwr, guard;
        logic [15:0] rd_addr;
        ce_mode = 0;
        trace.delete();
        rd_addr = 16'h9000;
        bus_cycle(REG_ADDR, 8'($urandom_range(0, 254)), 1'b0, 1'b1, tries);
        nwr = 0;
        guard = 0;
        while (nwr < 100 && guard < 400) begin
            step(rd_addr, 8'h00, 1'b1, 1'b0);
            nwr = 0;
            foreach (trace[k]) if (trace[k].mw) nwr++;
            guard++;
        end
        @(negedge clk);
        reset_n = 1'b0;
        ce = 1'b1;
        #1;
        vectors++;
        if (dma_active !== 1'b0 || cpu_ce !== 1'b1 || bus_aout !== rd_addr || bus_mr !== 1'b1 || bus_mw !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got act=%b ce=%b a=%h mr=%b mw=%b expected act=0 ce=1 a=%h mr=1 mw=0",
                     dma_active, cpu_ce, bus_aout, bus_mr, bus_mw, rd_addr);
        end
        ce = 1'b0;
        #1 reset_n = 1'b1;
        ce_cnt = 0;
        test_dma(8'hFF, 8'h00, -1, 0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        test_reset();
        test_dma(8'h02, 8'h00, 1, 0, 1'b0);
        test_dma(8'h02, 8'h00, 0, 0, 1'b0);
        test_dma(8'h31, 8'($urandom_range(2, 255)), 1, 0, 1'b1);
        test_dma(8'($urandom), 8'h00, -1, 1, 1'b0);
        test_dma(8'($urandom), 8'h00, -1, 2, 1'b0);
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
